// File: rtl/div_pkg.sv
// Shared widths, FSM encoding and handshake levels for the DIV/DIVU divider.
package div_pkg;

    localparam int unsigned RegBus       = 32;
    localparam int unsigned DoubleRegBus = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock, 32 iterations.
// Result is {remainder, quotient}, held with ready_o until EX drops start_i.
module div
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [RegBus-1:0]       opdata1_i,
    input  logic [RegBus-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DoubleRegBus-1:0] result_o,
    output logic                    ready_o
);

    div_state_t               r_state;
    logic [5:0]               r_cnt;
    logic [DoubleRegBus:0]    r_work;
    logic [RegBus-1:0]        r_divisor;
    logic                     r_sign1;
    logic                     r_sign2;
    logic                     r_signed;

    logic [RegBus-1:0]        w_abs1;
    logic [RegBus-1:0]        w_abs2;
    logic [RegBus+1:0]        w_diff;
    logic [DoubleRegBus:0]    w_next;
    logic [RegBus-1:0]        w_quo;
    logic [RegBus-1:0]        w_rem;

    always_comb begin
        w_abs1 = (signed_div_i && opdata1_i[RegBus-1]) ? (~opdata1_i + 32'd1) : opdata1_i;
        w_abs2 = (signed_div_i && opdata2_i[RegBus-1]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // Trial subtraction is taken on the pre-shift bits [64:31], i.e. the upper
    // 33 bits after a one-bit left shift; bit 33 of the difference is its sign.
    always_comb begin
        w_diff = r_work[DoubleRegBus:RegBus-1] - {2'b00, r_divisor};
        if (!w_diff[RegBus+1]) begin
            w_next = {w_diff[RegBus:0], r_work[RegBus-2:0], 1'b1};
        end else begin
            w_next = {r_work[DoubleRegBus-1:0], 1'b0};
        end
        w_quo = w_next[RegBus-1:0];
        w_rem = w_next[DoubleRegBus-1:RegBus];
        if (r_signed && (r_sign1 ^ r_sign2)) begin
            w_quo = '0 - w_next[RegBus-1:0];
        end
        if (r_signed && r_sign1) begin
            w_rem = '0 - w_next[DoubleRegBus-1:RegBus];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DivFree;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            case (r_state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            r_state <= DivByZero;
                        end else begin
                            r_work    <= {33'b0, w_abs1};
                            r_divisor <= w_abs2;
                            r_sign1   <= signed_div_i & opdata1_i[RegBus-1];
                            r_sign2   <= signed_div_i & opdata2_i[RegBus-1];
                            r_signed  <= signed_div_i;
                            r_cnt     <= '0;
                            r_state   <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                    r_state  <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        r_cnt   <= '0;
                        r_state <= DivFree;
                    end else begin
                        r_work <= w_next;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            result_o <= {w_rem, w_quo};
                            ready_o  <= DivResultReady;
                            r_state  <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                        r_state  <= DivFree;
                    end
                end
                default: r_state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block: latency, results, hold/release, annul, reset.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    // Stimulus only: issue a request and count clocks (accept edge = 1) until ready_o.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [63:0] res);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = 0;
        res          = 'x;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            if (ready_o === 1'b1) begin
                res = result_o;
                break;
            end
        end
        if (ready_o !== 1'b1) lat = -1;
    endtask

    task automatic release_start();
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", ready_o);
        end
        checks++;
        if (result_o !== 64'h0) begin
            errors++; $display("FAIL reset_result got=%h exp=0", result_o);
        end
    endtask

    task automatic test_unsigned();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL u100_7_latency got=%0d exp=33", lat); end
        checks++;
        if (res !== {32'h2, 32'hE}) begin errors++; $display("FAIL u100_7_result got=%h exp=%h", res, {32'h2, 32'hE}); end
        repeat (3) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || result_o !== {32'h2, 32'hE}) begin
            errors++; $display("FAIL u100_7_hold got=%b/%h exp=1/%h", ready_o, result_o, {32'h2, 32'hE});
        end
        release_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL u100_7_release got=%b/%h exp=0/0", ready_o, result_o);
        end
        do_div(1'b0, 32'hFFFFFFFF, 32'h1, lat, res);
        checks++;
        if (res !== {32'h0, 32'hFFFFFFFF}) begin errors++; $display("FAIL uffff_1_result got=%h exp=%h", res, {32'h0, 32'hFFFFFFFF}); end
        release_start();
    endtask

    task automatic test_signed();
        int lat; logic [63:0] res;
        do_div(1'b1, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++;
        if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin errors++; $display("FAIL s_m7_2_result got=%h exp=%h", res, {32'hFFFFFFFF, 32'hFFFFFFFD}); end
        release_start();
        do_div(1'b0, 32'hFFFFFFF9, 32'h2, lat, res);
        checks++;
        if (res !== {32'h1, 32'h7FFFFFFC}) begin errors++; $display("FAIL u_m7_2_result got=%h exp=%h", res, {32'h1, 32'h7FFFFFFC}); end
        release_start();
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== {32'h0, 32'h80000000}) begin errors++; $display("FAIL s_min_m1_result got=%h exp=%h", res, {32'h0, 32'h80000000}); end
        release_start();
    endtask

    task automatic test_by_zero();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd5, 32'd0, lat, res);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL div0_latency got=%0d exp=2", lat); end
        checks++;
        if (res !== 64'h0) begin errors++; $display("FAIL div0_result got=%h exp=0", res); end
        repeat (2) @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL div0_hold got=%b exp=1", ready_o); end
        release_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL div0_release got=%b/%h exp=0/0", ready_o, result_o);
        end
    endtask

    task automatic test_start_annul_same_cycle();
        int seen = 0;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL start_annul_not_accepted got=%0d ready cycles exp=0", seen); end
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_annul();
        int lat; logic [63:0] res; int seen = 0;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || result_o !== 64'h0) begin
            errors++; $display("FAIL annul_no_ready got=%0d/%h exp=0/0", seen, result_o);
        end
        do_div(1'b0, 32'd9, 32'd3, lat, res);
        checks++;
        if (lat !== 33 || res !== {32'h0, 32'h3}) begin
            errors++; $display("FAIL annul_then_9_3 got=%0d/%h exp=33/%h", lat, res, {32'h0, 32'h3});
        end
        release_start();
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [63:0] res;
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 64'h0) begin
            errors++; $display("FAIL rst_mid_op got=%b/%h exp=0/0", ready_o, result_o);
        end
        do_div(1'b0, 32'd50, 32'd5, lat, res);
        checks++;
        if (lat !== 33 || res !== {32'h0, 32'd10}) begin
            errors++; $display("FAIL rst_then_50_5 got=%0d/%h exp=33/%h", lat, res, {32'h0, 32'd10});
        end
        release_start();
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] res;
        do_div(1'b0, 32'd1000, 32'd10, lat, res);
        checks++;
        if (res !== {32'h0, 32'd100}) begin errors++; $display("FAIL b2b_first got=%h exp=%h", res, {32'h0, 32'd100}); end
        release_start();
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, lat, res);
        checks++;
        if (lat !== 33 || res !== {32'h1, 32'hFFFFFFFD}) begin
            errors++; $display("FAIL b2b_second got=%0d/%h exp=33/%h", lat, res, {32'h1, 32'hFFFFFFFD});
        end
        release_start();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_by_zero();
        test_start_annul_same_cycle();
        test_annul();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving the execute stage for DIV/DIVU. EX issues operands with a start request and holds its stall output high until this block reports a result. EX then writes the 64-bit result into HI/LO: remainder to HI, quotient to LO. The block is a radix-2 restoring divider with a four-state control FSM and one quotient bit per clock.

## Interface
Parameters: none. Widths come from shared constants: RegBus = 32, DoubleRegBus = 64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled at accept
- opdata1_i  in  32  dividend; sampled at accept
- opdata2_i  in  32  divisor; sampled at accept
- start_i  in  1  request; EX holds it high until it sees ready_o
- annul_i  in  1  abort the in-flight division (branch flush or exception)
- result_o  out  64  {remainder, quotient}; registered
- ready_o  out  1  result valid; registered

## Operation
States: FREE, BY_ZERO, ON, END (2-bit encoding).

FREE
- Accept happens on the edge where start_i=1 and annul_i=0.
- If opdata2_i==0: go to BY_ZERO.
- Otherwise, when signed_div_i=1, replace each negative operand with its two's-complement magnitude.
- Latch the magnitudes, the signs, and signed_div_i. Clear the 65-bit working register to {33'b0, |dividend|}. Set cnt=0 and go to ON.

BY_ZERO
- Load a zero result and go to END.

ON
- If annul_i=1: go to FREE. ready_o stays 0 and result_o stays 0.
- Otherwise perform one iteration:
  - Trial-subtract the divisor from the upper 33 bits of the working register.
  - If the difference is non-negative, shift in quotient bit 1 and keep the difference.
  - Otherwise shift in 0 and keep the original value.
  - Increment cnt.
- On the iteration with cnt==31:
  - Apply sign fixups: quotient is negated when sign1^sign2; remainder takes the sign of the dividend. Fixups apply only when the latched signed flag is 1.
  - Register the 64-bit result and go to END.

END
- ready_o=1 and result_o is held.
- When start_i=0: go to FREE and clear ready_o and result_o.
- annul_i is ignored in END.

Arithmetic
- All operations are modulo 2^32.
- 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0. No trap.

Reset
- rst forces state FREE, cnt=0, ready_o=0, result_o=0 and clears the working register, from any state, including mid-operation.

## Timing
- Accept at edge k.
- Normal division: ON covers the cycles after edges k..k+31. ready_o=1 is visible after edge k+32 (33 clocks from the request being sampled, including the accept cycle).
- Divide by zero: ready_o is visible after edge k+1.
- ready_o stays high while start_i stays high. It drops the cycle after EX deasserts start_i.
- A back-to-back division needs one FREE cycle with start_i=0 first.
- annul_i in ON takes effect at the next edge. Operands change freely after accept.
- Simultaneous start_i=1 and annul_i=1 in FREE: the request is not accepted.
- rst has priority over annul_i, which has priority over start_i.

## Structure
These constants are added to defines.v:
- DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11
- DivResultReady/DivResultNotReady
- DivStart/DivStop

There is no natural sub-module: the FSM, 6-bit counter, 65-bit working register and sign fixup fit in one module (about 150–200 lines). EX gains the start/annul/operand drive and stall = start & ~ready for DIV/DIVU. It selects result_o into hi_o/lo_o with whilo_o=1.

## Test plan
- Unsigned 100/7, start held: ready_o rises 33 clocks after accept. result_o = {0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Same operands unsigned: quotient 0x7FFFFFFC, remainder 0x00000001.
- 5/0: ready_o high 2 clocks after accept, result_o = 0. Holds while start_i=1; after start_i=0, ready_o=0 and result_o=0 the next cycle.
- Signed 0x80000000/0xFFFFFFFF gives {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/0x00000001 gives {0x00000000, 0xFFFFFFFF}.
- annul_i pulsed 10 cycles into ON: FREE next cycle and ready_o never rises. A following 9/3 request completes normally: {0, 3}.
- rst asserted during ON (cycle 20): next cycle ready_o=0 and result_o=0, FSM in FREE. The next accepted 50/5 request gives {0, 10}.
